// File: rtl/seg7_scan_decoder_if.sv
// Bus bundle between a scanned active-low 7-segment display and its decoder.
// The master drives the segment/anode lines; the slave returns the decoded digits.
interface seg7_scan_decoder_if #(
   parameter int DIGITS = 4
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [6:0]          seg_n;
   logic [DIGITS-1:0]   an_n;
   logic [4*DIGITS-1:0] bcd_out;
   logic [DIGITS-1:0]   digit_valid;
   logic                err;
   logic [IDX_W-1:0]    err_digit;
   logic                frame_done;

   modport master (
      output seg_n, an_n,
      input  bcd_out, digit_valid, err, err_digit, frame_done
   );

   modport slave (
      input  seg_n, an_n,
      output bcd_out, digit_valid, err, err_digit, frame_done
   );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Reconstructs per-digit BCD values from a multiplexed active-low 7-segment bus.
// Define SEG7_SYNC_EN to put a two-flop synchronizer on the inputs (else one register).
module seg7_scan_decoder #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4
) (
   input logic                clk,
   input logic                rst,
   seg7_scan_decoder_if.slave bus
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int SW    = DIGITS + 7;
   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

   function automatic logic [3:0] decode_seg(input logic [6:0] seg);
      logic [3:0] code;
      case (seg)
         7'b1000000: code = 4'd0;
         7'b1111001: code = 4'd1;
         7'b0100100: code = 4'd2;
         7'b0110000: code = 4'd3;
         7'b0011001: code = 4'd4;
         7'b0010010: code = 4'd5;
         7'b0000010: code = 4'd6;
         7'b1011000: code = 4'd7;
         7'b0000000: code = 4'd8;
         7'b0011000: code = 4'd9;
         7'b1111111: code = 4'hF;
         default:    code = 4'hE;
      endcase
      return code;
   endfunction

   // Input stage: reset to all ones so the first samples look like an idle bus
   logic [SW-1:0] s_d, s_q;
   assign s_d = {bus.an_n, bus.seg_n};

`ifdef SEG7_SYNC_EN
   logic [SW-1:0] meta_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '1;
         s_q    <= '1;
      end else begin
         meta_q <= s_d;
         s_q    <= meta_q;
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) s_q <= '1;
      else     s_q <= s_d;
   end
`endif

   state_t              state_d, state_q;
   logic [SW-1:0]       prev_d, prev_q;
   logic [7:0]          cnt_d, cnt_q;
   logic [4*DIGITS-1:0] bcd_d, bcd_q;
   logic [DIGITS-1:0]   valid_d, valid_q;
   logic [DIGITS-1:0]   seen_d, seen_q;
   logic                err_d, err_q;
   logic                frame_d, frame_q;
   logic [IDX_W-1:0]    err_digit_d, err_digit_q;

   logic [DIGITS-1:0] an_low;
   logic              qual, same, commit;
   logic [IDX_W-1:0]  idx;
   logic [3:0]        code;

   assign an_low = ~s_q[SW-1:7];
   // Exactly one anode low: nonzero and a power of two
   assign qual   = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
   assign same   = (s_q == prev_q);
   assign code   = decode_seg(s_q[6:0]);
   assign prev_d = s_q;

   always_comb begin
      idx = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (an_low[i]) idx = IDX_W'(i);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!qual)                cnt_d = 8'd0;
      else if (!same)           cnt_d = 8'd1;
      else if (cnt_q < STABLE)  cnt_d = cnt_q + 8'd1;
   end

   always_comb begin
      state_d = state_q;
      commit  = 1'b0;
      case (state_q)
         IDLE:  if (qual) state_d = TRACK;
         TRACK: begin
            if (!qual) state_d = IDLE;
            else if (same && cnt_q != STABLE && cnt_d == STABLE) begin
               commit  = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (!qual)      state_d = IDLE;
            else if (!same) state_d = TRACK;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bcd_d       = bcd_q;
      valid_d     = valid_q;
      seen_d      = seen_q;
      err_d       = 1'b0;
      frame_d     = 1'b0;
      err_digit_d = err_digit_q;
      if (commit) begin
         bcd_d[idx*4 +: 4] = code;
         valid_d[idx]      = (code <= 4'd9);
         if (code == 4'hE) begin
            err_d       = 1'b1;
            err_digit_d = idx;
         end
         seen_d[idx] = 1'b1;
         // The completing digit is not carried into the next frame
         if (seen_d == '1) begin
            frame_d = 1'b1;
            seen_d  = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         prev_q      <= '1;
         cnt_q       <= 8'd0;
         bcd_q       <= '1;
         valid_q     <= '0;
         seen_q      <= '0;
         err_q       <= 1'b0;
         frame_q     <= 1'b0;
         err_digit_q <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         cnt_q       <= cnt_d;
         bcd_q       <= bcd_d;
         valid_q     <= valid_d;
         seen_q      <= seen_d;
         err_q       <= err_d;
         frame_q     <= frame_d;
         err_digit_q <= err_digit_d;
      end
   end

   assign bus.bcd_out     = bcd_q;
   assign bus.digit_valid = valid_q;
   assign bus.err         = err_q;
   assign bus.err_digit   = err_digit_q;
   assign bus.frame_done  = frame_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: hand-computed expectations for the
// single-digit, scan, illegal, ghosting, glitch, blank and reset scenarios.
module tb_seg7_scan_decoder;
   localparam int DIGITS = 4;
   localparam int S      = 4;
`ifdef SEG7_SYNC_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif
   // Ticks from driving a new bus value until the commit edge has passed
   localparam int LAT = L + S;

   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_7 = 7'b1011000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0011000;
   localparam logic [6:0] SEG_BAD   = 7'b1110111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg7_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

   seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   int err_pulses = 0;
   int fd_pulses = 0;

   always @(negedge clk) begin
      if (bus.err === 1'b1)        err_pulses++;
      if (bus.frame_done === 1'b1) fd_pulses++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [DIGITS-1:0] an, input logic [6:0] seg);
      bus.an_n  = an;
      bus.seg_n = seg;
   endtask

   int e0, f0;
   logic [15:0] bcd_snap;
   logic [3:0]  val_snap;

   initial begin
      drive(4'b1111, SEG_BLANK);
      tick(3);
      chk("rst_bcd", 32'(bus.bcd_out), 32'hFFFF);
      chk("rst_valid", 32'(bus.digit_valid), 32'h0);
      chk("rst_err", 32'(bus.err), 32'h0);
      chk("rst_frame", 32'(bus.frame_done), 32'h0);
      chk("rst_errdig", 32'(bus.err_digit), 32'h0);
      rst = 1'b0;
      tick(2);
      chk("idle_bcd", 32'(bus.bcd_out), 32'hFFFF);

      // Digit 0 shows '2'
      e0 = err_pulses;
      drive(4'b1110, SEG_2);
      tick(LAT - 1);
      chk("d0_pre", 32'(bus.bcd_out), 32'hFFFF);
      tick(1);
      chk("d0_bcd", 32'(bus.bcd_out), 32'hFFF2);
      chk("d0_valid", 32'(bus.digit_valid), 32'h1);
      tick(10 - LAT);
      chk("d0_hold", 32'(bus.bcd_out), 32'hFFF2);
      chk("d0_noerr", 32'(err_pulses - e0), 32'h0);

      // Scan 1,2,3,4 across digits 0..3
      e0 = err_pulses;
      f0 = fd_pulses;
      drive(4'b1110, SEG_1); tick(6);
      drive(4'b1101, SEG_2); tick(6);
      drive(4'b1011, SEG_3); tick(6);
      chk("scan_nofd", 32'(fd_pulses - f0), 32'h0);
      drive(4'b0111, SEG_4);
      tick(LAT - 1);
      chk("scan_fd_pre", 32'(bus.frame_done), 32'h0);
      chk("scan_bcd_pre", 32'(bus.bcd_out), 32'hF321);
      tick(1);
      chk("scan_fd", 32'(bus.frame_done), 32'h1);
      chk("scan_bcd", 32'(bus.bcd_out), 32'h4321);
      chk("scan_valid", 32'(bus.digit_valid), 32'hF);
      tick(1);
      chk("scan_fd_end", 32'(bus.frame_done), 32'h0);
      tick(3);
      chk("scan_fd_once", 32'(fd_pulses - f0), 32'h1);
      chk("scan_noerr", 32'(err_pulses - e0), 32'h0);

      // Illegal pattern on digit 2
      e0 = err_pulses;
      drive(4'b1011, SEG_BAD);
      tick(LAT - 1);
      chk("bad_pre", 32'(bus.err), 32'h0);
      tick(1);
      chk("bad_err", 32'(bus.err), 32'h1);
      chk("bad_errdig", 32'(bus.err_digit), 32'h2);
      chk("bad_bcd", 32'(bus.bcd_out), 32'h4E21);
      chk("bad_valid", 32'(bus.digit_valid), 32'b1011);
      tick(1);
      chk("bad_err_end", 32'(bus.err), 32'h0);
      tick(4);
      chk("bad_once", 32'(err_pulses - e0), 32'h1);
      chk("bad_errdig_hold", 32'(bus.err_digit), 32'h2);

      // Ghosting: two anodes low
      e0 = err_pulses;
      f0 = fd_pulses;
      bcd_snap = bus.bcd_out;
      val_snap = bus.digit_valid;
      drive(4'b1100, SEG_5);
      tick(20);
      chk("ghost_bcd", 32'(bus.bcd_out), 32'(bcd_snap));
      chk("ghost_bcd_abs", 32'(bus.bcd_out), 32'h4E21);
      chk("ghost_valid", 32'(bus.digit_valid), 32'(val_snap));
      chk("ghost_err", 32'(err_pulses - e0), 32'h0);
      chk("ghost_fd", 32'(fd_pulses - f0), 32'h0);
      chk("ghost_errdig", 32'(bus.err_digit), 32'h2);

      // Digit 1 holds '9', glitches to '8' for S-1 samples, returns
      drive(4'b1101, SEG_9);
      tick(LAT);
      chk("g9_bcd", 32'(bus.bcd_out), 32'h4E91);
      tick(2);
      drive(4'b1101, SEG_8);
      for (int i = 0; i < S - 1; i++) begin
         tick(1);
         chk("glitch_f1", 32'(bus.bcd_out[7:4]), 32'h9);
      end
      drive(4'b1101, SEG_9);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("glitch_f1_after", 32'(bus.bcd_out[7:4]), 32'h9);
      end
      chk("glitch_valid", 32'(bus.digit_valid), 32'b1011);

      // Blank on digit 0
      e0 = err_pulses;
      drive(4'b1110, SEG_BLANK);
      tick(LAT);
      chk("blank_bcd", 32'(bus.bcd_out), 32'h4E9F);
      chk("blank_valid", 32'(bus.digit_valid), 32'b1010);
      chk("blank_noerr", 32'(err_pulses - e0), 32'h0);

      // Reset one cycle before a pending commit
      drive(4'b0111, SEG_7);
      tick(LAT - 1);
      rst = 1'b1;
      #1;
      chk("rr_bcd", 32'(bus.bcd_out), 32'hFFFF);
      chk("rr_valid", 32'(bus.digit_valid), 32'h0);
      chk("rr_errdig", 32'(bus.err_digit), 32'h0);
      chk("rr_err", 32'(bus.err), 32'h0);
      tick(1);
      chk("rr_bcd_edge", 32'(bus.bcd_out), 32'hFFFF);
      rst = 1'b0;
      tick(LAT - 1);
      chk("rr_pre", 32'(bus.bcd_out), 32'hFFFF);
      tick(1);
      chk("rr_bcd_after", 32'(bus.bcd_out), 32'h7FFF);
      chk("rr_valid_after", 32'(bus.digit_valid), 32'b1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=%0d exp=%0d", 0, 1);
      $fatal(1, "timeout");
   end
endmodule
